// File: rtl/shiftanddivide_pkg.sv
// Shared definitions for the sequential arithmetic units.
// State codes are kept common with the shift-and-add multiplier.
package shiftanddivide_pkg;

    typedef enum logic [1:0] {
        S1 = 2'b00,
        S2 = 2'b01,
        S3 = 2'b10
    } state_t;

    localparam int N_DEF = 32;

endpackage

// File: rtl/shiftanddivide_divstep.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, returning the next remainder and the quotient bit.
module shiftanddivide_divstep #(
    parameter int n = 32
) (
    input  logic [n-1:0] rem,
    input  logic         msb,
    input  logic [n-1:0] div,
    output logic [n-1:0] rem_next,
    output logic         qbit
);

    logic [n:0] t;
    logic [n:0] d;

    always_comb begin
        t = {rem, msb};
        d = t - {1'b0, div};
        // a clear top bit means no borrow, so the subtraction is kept
        qbit     = ~d[n];
        rem_next = qbit ? d[n-1:0] : t[n-1:0];
    end

endmodule

// File: rtl/shiftanddivide.sv
// Sequential restoring unsigned divider, one quotient bit per clock, driven by
// the same LA/LB/s/Finish handshake as the shift-and-add multiplier.
//
// state | meaning
// S1    | idle/load: LA/LB load operands, remainder cleared, counter preset
// S2    | compute: one shift-and-subtract iteration per cycle
// S3    | done: Finish high, Q/R held while s stays high
module shiftanddivide
    import shiftanddivide_pkg::*;
#(
    parameter int n  = N_DEF,
    parameter int CW = $clog2(n)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         LA,
    input  logic         LB,
    input  logic         s,
    input  logic [n-1:0] DataA,
    input  logic [n-1:0] DataB,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         Finish
);

    state_t        state;
    logic [n-1:0]  a_reg;
    logic [n-1:0]  b_reg;
    logic [n-1:0]  r_reg;
    logic [CW-1:0] count;
    logic          fin;
    logic [n-1:0]  rem_next;
    logic          qbit;

    shiftanddivide_divstep #(.n(n)) u_divstep (
        .rem      (r_reg),
        .msb      (a_reg[n-1]),
        .div      (b_reg),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S1;
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
            count <= '0;
            fin   <= 1'b0;
        end else begin
            case (state)
                S1: begin
                    fin   <= 1'b0;
                    r_reg <= '0;
                    count <= CW'(n - 1);
                    if (LA) a_reg <= DataA;
                    if (LB) b_reg <= DataB;
                    if (s)  state <= S2;
                end
                S2: begin
                    r_reg <= rem_next;
                    a_reg <= {a_reg[n-2:0], qbit};
                    // the final iteration shares its edge with the move to S3
                    if (count == '0) begin
                        state <= S3;
                        fin   <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S3: begin
                    if (!s) begin
                        state <= S1;
                        fin   <= 1'b0;
                    end
                end
                default: begin
                    state <= S1;
                    a_reg <= '0;
                    r_reg <= '0;
                    fin   <= 1'b0;
                end
            endcase
        end
    end

    assign Q      = a_reg;
    assign R      = r_reg;
    assign Finish = fin;

endmodule

// File: tb/tb_shiftanddivide.sv
// Scoreboard bench for shiftanddivide: expected quotient/remainder come from
// plain integer division and are checked whenever Finish rises.
module tb_shiftanddivide;

    localparam int n = 32;

    logic         clk;
    logic         resetn;
    logic         LA;
    logic         LB;
    logic         s;
    logic [n-1:0] DataA;
    logic [n-1:0] DataB;
    logic [n-1:0] Q;
    logic [n-1:0] R;
    logic         Finish;

    int tests = 0;
    int fails = 0;
    int pushed = 0;
    int popped = 0;

    logic [2*n-1:0] sb[$];
    logic           fin_q = 1'b0;

    shiftanddivide #(.n(n)) dut (
        .clk    (clk),
        .resetn (resetn),
        .LA     (LA),
        .LB     (LB),
        .s      (s),
        .DataA  (DataA),
        .DataB  (DataB),
        .Q      (Q),
        .R      (R),
        .Finish (Finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*n-1:0] model(input logic [n-1:0] a, input logic [n-1:0] b);
        logic [n-1:0] q;
        logic [n-1:0] r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // monitor: compare on every rising Finish
    always @(negedge clk) begin
        if (Finish && !fin_q) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", 64'(Finish), 64'd0);
            end else begin
                logic [2*n-1:0] e;
                e = sb.pop_front();
                popped++;
                check("quotient", 64'(Q), 64'(e[2*n-1:n]));
                check("remainder", 64'(R), 64'(e[n-1:0]));
            end
        end
        fin_q = Finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal with hold; mode 1: LA/LB pulse during compute; mode 2: s dropped in compute
    task automatic do_div(input logic [n-1:0] a, input logic [n-1:0] b, input int mode);
        logic [2*n-1:0] e;
        int lat;
        e = model(a, b);
        DataA = a;
        DataB = b;
        LA = 1'b1;
        LB = 1'b1;
        tick();
        LA = 1'b0;
        LB = 1'b0;
        check("load_q", 64'(Q), 64'(a));
        check("load_r", 64'(R), 64'd0);
        sb.push_back(e);
        pushed++;
        s = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (mode == 1 && i == 5) begin
                LA = 1'b1;
                LB = 1'b1;
                DataA = $urandom;
                DataB = $urandom;
            end else if (mode == 1 && i == 6) begin
                LA = 1'b0;
                LB = 1'b0;
            end
            if (mode == 2 && i == 3) s = 1'b0;
            if (Finish) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(n + 1));
        if (mode == 2) begin
            tick();
            check("one_cycle_finish", 64'(Finish), 64'd0);
        end else begin
            tick();
            tick();
            check("finish_hold", 64'(Finish), 64'd1);
            check("q_hold", 64'(Q), 64'(e[2*n-1:n]));
            check("r_hold", 64'(R), 64'(e[n-1:0]));
            s = 1'b0;
            tick();
            check("finish_clear", 64'(Finish), 64'd0);
        end
    endtask

    initial begin
        logic [n-1:0] ra;
        logic [n-1:0] rb;
        resetn = 1'b0;
        LA = 1'b0;
        LB = 1'b0;
        s = 1'b0;
        DataA = '0;
        DataB = '0;
        #12;
        check("reset_q", 64'(Q), 64'd0);
        check("reset_r", 64'(R), 64'd0);
        check("reset_finish", 64'(Finish), 64'd0);
        resetn = 1'b1;
        tick();

        do_div(32'd100, 32'd7, 0);
        do_div(32'hFFFFFFFF, 32'd1, 0);
        do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_div(32'd5, 32'd9, 0);
        do_div(32'd0, 32'd3, 0);
        do_div(32'd1234, 32'd0, 0);

        // abort mid-computation with an asynchronous reset
        DataA = 32'd1000;
        DataB = 32'd10;
        LA = 1'b1;
        LB = 1'b1;
        tick();
        LA = 1'b0;
        LB = 1'b0;
        s = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        resetn = 1'b0;
        #1;
        check("abort_q", 64'(Q), 64'd0);
        check("abort_r", 64'(R), 64'd0);
        check("abort_finish", 64'(Finish), 64'd0);
        s = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
        do_div(32'd1000, 32'd10, 0);

        do_div(32'd77, 32'd8, 1);
        do_div(32'd1000000, 32'd3, 2);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) rb = '0;
            do_div(ra, rb, int'($urandom_range(0, 2)));
        end

        tick();
        tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("all_results_seen", 64'(popped), 64'(pushed));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shiftanddivide.md
Name: shiftanddivide

Overview:
- Sequential restoring (shift-and-subtract) unsigned divider; the inverse of the team's shift-and-add multiplier.
- Uses the same load/start/finish handshake (LA, LB, s, Finish) so the datapath controller can drive either arithmetic unit identically.
- One quotient bit is produced per clock over n iterations. Quotient and remainder are presented on registered outputs.

Parameters:
- n, 32, operand width in bits (dividend, divisor, quotient and remainder are all n bits).
- CW, $clog2(n), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- LA  input  1  load DataA (dividend) into the quotient/dividend shift register.
- LB  input  1  load DataB (divisor) into the divisor register.
- s  input  1  start/hold request (same semantics as the multiplier).
- DataA  input  n  dividend.
- DataB  input  n  divisor.
- Q  output  n  quotient; valid while Finish=1.
- R  output  n  remainder; valid while Finish=1.
- Finish  output  1  result valid; high in state S3 only.

Behaviour:
- Reset (resetn=0, async): state=S1; Q, R, divisor register and counter cleared to 0; Finish=0.
- States:
  - S1 (idle/load): LA loads A-reg<=DataA; LB loads B-reg<=DataB; R-reg is cleared to 0 every cycle; counter<=n-1. s=1 -> S2, else stay in S1.
  - S2 (compute): one iteration per cycle. If counter==0 at the edge -> S3, else decrement the counter.
  - S3 (done): Finish=1. Q/R are held. s=1 -> stay in S3; s=0 -> S1.
- LA/LB are honoured only in S1; ignored in S2/S3. LA and LB may be asserted in the same cycle.
- Iteration step in S2 (combinational, width n+1):
  - T = {R-reg, A-reg[n-1]}.
  - D = T - {1'b0, B-reg}.
  - If D[n]==0 (no borrow): R-reg<=D[n-1:0] and A-reg<={A-reg[n-2:0],1'b1}.
  - Else: R-reg<=T[n-1:0] and A-reg<={A-reg[n-2:0],1'b0}.
- Outputs: Q = A-reg, R = R-reg, driven straight from registers. Intermediate values are visible in S2; consumers must qualify with Finish.
- Latency: s sampled high in S1 at edge k -> S2 from k. Exactly n compute cycles, so Finish rises after edge k+n (n=32: the 33rd edge after start).
- s dropping during S2 does not abort; the operation completes and S3 is entered. If s=0 there, S3 returns to S1 at the next edge (Finish high for one cycle).
- Divide by zero (B-reg=0): no special case. Every subtraction succeeds, giving Q=all ones and R=dividend. No error flag.
- Divisor > dividend: Q=0, R=dividend.
- resetn asserted mid-operation: immediate abort to the reset values. No partial result is retained.
- Undefined state encoding (2'b11): next state S1, all outputs deasserted.

Decomposition:
- Shared package: state constants S1=2'b00, S2=2'b01, S3=2'b10, kept common with the multiplier; default operand width n=32.
- One natural sub-module, divstep: the combinational (n+1)-bit subtract/compare that returns the new remainder and the quotient bit.
- The existing regen register module can hold the divisor, with its reset adapted to active-low at instantiation via ~resetn.

Test Plan:
- DataA=100, DataB=7, LA=LB=1 in S1, then s=1 -> Finish rises exactly n+1 edges after s; Q=14, R=2. Finish holds while s=1 and clears one cycle after s=0.
- DataA=32'hFFFFFFFF, DataB=1 -> Q=32'hFFFFFFFF, R=0. DataA=32'hFFFFFFFF, DataB=32'hFFFFFFFF -> Q=1, R=0.
- DataA=5, DataB=9 -> Q=0, R=5. DataA=0, DataB=3 -> Q=0, R=0.
- DataA=1234, DataB=0 -> Q=32'hFFFFFFFF, R=1234; Finish asserted normally.
- Start 1000/10, pulse resetn low at compute cycle 10 -> Q=0, R=0, Finish=0, state S1. A fresh start then yields Q=100, R=0.
- Back-to-back: after Finish, drop s and reload 77/8 -> Q=9, R=5. An LA pulse during S2 must not corrupt the in-flight result.
